// File: rtl/multi_queue_fifo.sv
// Multi-channel FIFO: NUM_CH independent queues statically partitioned in one RAM,
// with per-channel status, sticky error flags and a registered read port.
module multi_queue_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = 12,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           write_enable,
  input  logic [CH_W-1:0]                write_ch,
  input  logic [DATA_WIDTH-1:0]          write_data_in,
  input  logic                           read_enable,
  input  logic [CH_W-1:0]                read_ch,
  output logic [DATA_WIDTH-1:0]          read_data_out,
  output logic                           read_valid,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH-1:0]              empty,
  output logic [NUM_CH-1:0]              almost_full,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] fifo_occu,
  output logic [NUM_CH-1:0]              overflow,
  output logic [NUM_CH-1:0]              underflow,
  input  logic [NUM_CH-1:0]              flag_clear
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int RAM_W = CH_W + ADDR_WIDTH;
  localparam int RAM_N = DEPTH * NUM_CH;

  logic [PW-1:0]         r_wptr [NUM_CH];
  logic [PW-1:0]         r_rptr [NUM_CH];
  logic [DATA_WIDTH-1:0] r_mem  [RAM_N];

  logic [PW-1:0]         w_occ  [NUM_CH];
  logic [NUM_CH-1:0]     w_wr_sel;
  logic [NUM_CH-1:0]     w_rd_sel;
  logic [NUM_CH-1:0]     w_wr_acc;
  logic [NUM_CH-1:0]     w_rd_acc;
  logic [NUM_CH-1:0]     w_ovf_set;
  logic [NUM_CH-1:0]     w_udf_set;
  logic [ADDR_WIDTH-1:0] w_wofs;
  logic [ADDR_WIDTH-1:0] w_rofs;
  logic [RAM_W-1:0]      w_waddr;
  logic [RAM_W-1:0]      w_raddr;
  logic                  w_wr_any;
  logic                  w_rd_any;

  // Per-channel status and acceptance; an out-of-range channel index selects nothing.
  // A full channel still accepts a write when the same channel is popped this cycle.
  always_comb begin
    w_wofs = '0;
    w_rofs = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_occ[c]       = r_wptr[c] - r_rptr[c];
      empty[c]       = (r_wptr[c] == r_rptr[c]);
      full[c]        = (r_wptr[c][ADDR_WIDTH] != r_rptr[c][ADDR_WIDTH]) &&
                       (r_wptr[c][ADDR_WIDTH-1:0] == r_rptr[c][ADDR_WIDTH-1:0]);
      almost_full[c] = (w_occ[c] >= PW'(AF_THRESH));
      fifo_occu[c*PW +: PW] = w_occ[c];
      w_wr_sel[c]    = write_enable && (write_ch == CH_W'(c));
      w_rd_sel[c]    = read_enable && (read_ch == CH_W'(c));
      w_rd_acc[c]    = w_rd_sel[c] && !empty[c];
      w_wr_acc[c]    = w_wr_sel[c] && (!full[c] || w_rd_acc[c]);
      w_ovf_set[c]   = w_wr_sel[c] && !w_wr_acc[c];
      w_udf_set[c]   = w_rd_sel[c] && !w_rd_acc[c];
      w_wofs = (write_ch == CH_W'(c)) ? r_wptr[c][ADDR_WIDTH-1:0] : w_wofs;
      w_rofs = (read_ch == CH_W'(c)) ? r_rptr[c][ADDR_WIDTH-1:0] : w_rofs;
    end
    w_waddr  = {write_ch, w_wofs};
    w_raddr  = {read_ch, w_rofs};
    w_wr_any = |w_wr_acc;
    w_rd_any = |w_rd_acc;
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_any) begin
      r_mem[w_waddr] <= write_data_in;
    end
  end

  // Pointer update; wrap bit rolls over naturally at 2^(ADDR_WIDTH+1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_acc[c]) begin
          r_wptr[c] <= r_wptr[c] + PW'(1);
        end
        if (w_rd_acc[c]) begin
          r_rptr[c] <= r_rptr[c] + PW'(1);
        end
      end
    end
  end

  // Registered read; the RAM read sees the pre-write contents, so a read+write
  // on a full channel returns the old head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_out <= '0;
      read_valid    <= 1'b0;
    end else begin
      if (w_rd_any) begin
        read_data_out <= r_mem[w_raddr];
        read_valid    <= 1'b1;
      end else begin
        read_valid    <= 1'b0;
      end
    end
  end

  // Sticky error flags; a set event in the same cycle beats flag_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= '0;
      underflow <= '0;
    end else begin
      overflow  <= (overflow & ~flag_clear) | w_ovf_set;
      underflow <= (underflow & ~flag_clear) | w_udf_set;
    end
  end

endmodule

// File: doc/multi_queue_fifo.md
Name: multi_queue_fifo

Overview:
- Single-clock, parametrised multi-channel FIFO. NUM_CH independent queues, each of depth 2^ADDR_WIDTH, are held in one statically partitioned RAM.
- Used in the switch as per-output-port virtual queues, behind the clock-domain-crossing FIFOs.
- Adds the following per channel: full, empty and almost-full flags; occupancy; sticky overflow and underflow flags; a registered read with a valid strobe; and same-cycle read/write on a full channel.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, log2 of per-channel depth. DEPTH = 2^ADDR_WIDTH.
- NUM_CH, 4, number of queues, ≥1. CH_W = max(1, clog2(NUM_CH)) is derived.
- AF_THRESH, 12, almost-full threshold in words, 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_enable  in  1  write request.
- write_ch  in  CH_W  target queue for the write.
- write_data_in  in  DATA_WIDTH  write data.
- read_enable  in  1  read request.
- read_ch  in  CH_W  source queue for the read.
- read_data_out  out  DATA_WIDTH  read data, registered.
- read_valid  out  1  read_data_out holds a newly popped word.
- full  out  NUM_CH  per-channel occupancy == DEPTH.
- empty  out  NUM_CH  per-channel occupancy == 0.
- almost_full  out  NUM_CH  per-channel occupancy ≥ AF_THRESH.
- fifo_occu  out  NUM_CH*(ADDR_WIDTH+1)  occupancy of channel c in bits [c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- overflow  out  NUM_CH  sticky: a write was dropped.
- underflow  out  NUM_CH  sticky: a read was rejected.
- flag_clear  in  NUM_CH  clears the overflow and underflow bits per channel.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All wptr/rptr = 0.
  - read_data_out = 0, read_valid = 0.
  - overflow = underflow = 0.
  - Hence empty = all 1, full = 0, almost_full = 0, fifo_occu = 0.
  - RAM contents are not reset.
  - Asserting reset mid-operation discards all queued data immediately. The first accepted write after release lands at offset 0.
- Pointers:
  - Each channel has an (ADDR_WIDTH+1)-bit wptr and rptr with a wrap bit; they wrap modulo 2^(ADDR_WIDTH+1).
  - Occupancy = wptr - rptr, computed modulo 2^(ADDR_WIDTH+1), range 0..DEPTH.
  - full: MSBs differ and lower bits are equal. empty: pointers are equal.
- RAM:
  - DEPTH*NUM_CH words.
  - Address = ch*DEPTH + ptr[ADDR_WIDTH-1:0].
  - One write port and one read port.
- Write acceptance: write_enable && write_ch < NUM_CH && (!full[write_ch] || read accepted from the same channel this cycle).
  - On accept: store at the next edge and increment wptr.
  - If the channel is full and not being read: drop the write, set overflow[write_ch] at the next edge, leave pointers and data unchanged.
- Read acceptance: read_enable && read_ch < NUM_CH && !empty[read_ch].
  - On accept: at the next edge, read_data_out = head word, read_valid = 1, rptr increments.
  - Latency is 1 cycle from request to data.
  - If the channel is empty: read_valid = 0 next cycle, read_data_out holds its previous value, underflow[read_ch] is set.
  - There is no write-to-read bypass. A write and read to the same empty channel in the same cycle gives: write accepted, read rejected with underflow set, occupancy 0→1.
- read_valid is a 1-cycle pulse per accepted read. With back-to-back reads it stays high continuously.
- Simultaneous accepted read and write on the same channel: occupancy unchanged, and this includes the full case. The read returns the old head.
- Simultaneous read and write on different channels: independent.
- Out-of-range channel: a channel index ≥ NUM_CH (possible when NUM_CH is not a power of 2) is ignored. No state change and no flag set.
- Flag/flag_clear priority:
  - flag_clear[c] clears the bit at the next edge.
  - If a set event occurs for the same bit in the same cycle, set wins.
- Status outputs: full, empty, almost_full and fifo_occu are combinational from the pointer registers. They reflect the state after the last edge, with no look-ahead.

Test Plan:
- Reset, then write 16 words 0x00..0x0F to ch2 with NUM_CH=4, ADDR_WIDTH=4 → full[2]=1, fifo_occu ch2=16, almost_full[2] high from occupancy 12, other channels empty=1.
- Interleave writes A0,B0,A1,B1 to ch0/ch1, then read ch1 twice and ch0 twice → read_data_out sequence B0,B1,A0,A1, each 1 cycle after its read_enable, read_valid high 4 cycles.
- Fill ch3 (16 words), then write 0xEE with no read → overflow[3]=1, occupancy stays 16, subsequent reads return the original 16 words. Pulse flag_clear[3] → overflow[3]=0.
- Fill ch0, then same-cycle read ch0 + write 0x55 → read returns word 0, occupancy stays 16, 0x55 is returned as the 16th subsequent read.
- Read empty ch1 together with a write of 0x77 to ch1 → read_valid=0, underflow[1]=1, occupancy 1. The next read returns 0x77.
- Fill ch0 to 16+wrap via 40 write/read pairs, assert reset_n low mid-burst → within the same cycle empty=all 1 and read_valid=0. After release, a write then read returns the written data.
